// File: rtl/flood_engine_if.sv
// Board-engine bus: game handshake, move request, board-fill write port and display read port.
interface flood_engine_if;
    logic [4:0] final_SIZE;
    logic [3:0] final_COLOR_NUM;
    logic       BEGIN_GAME;
    logic       ACK_BEGIN_GAME;
    logic       COLOR_SEL_SIG;
    logic [2:0] COLOR_SELECTED;
    logic       CURRENTLY_CHANGING_COLOR;
    logic       LOAD_WE;
    logic [9:0] LOAD_ADDR;
    logic [2:0] LOAD_COLOR;
    logic [9:0] RD_ADDR;
    logic [2:0] RD_COLOR;
    logic       RD_OWNED;
    logic       INITIALIZED;
    logic       GAME_WON;

    modport slave (
        input  final_SIZE, final_COLOR_NUM, BEGIN_GAME, COLOR_SEL_SIG, COLOR_SELECTED,
               LOAD_WE, LOAD_ADDR, LOAD_COLOR, RD_ADDR,
        output ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, RD_COLOR, RD_OWNED,
               INITIALIZED, GAME_WON
    );

    modport master (
        output final_SIZE, final_COLOR_NUM, BEGIN_GAME, COLOR_SEL_SIG, COLOR_SELECTED,
               LOAD_WE, LOAD_ADDR, LOAD_COLOR, RD_ADDR,
        input  ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, RD_COLOR, RD_OWNED,
               INITIALIZED, GAME_WON
    );
endinterface

// File: rtl/flood_engine.sv
// Flood-it board engine: repeated raster sweeps grow the owned region until a pass changes nothing.
// Define FLOOD_WIN_DETECT_EN to build the owned-cell counter that drives GAME_WON.
module flood_engine (
    input logic           MASTER_CLOCK,
    input logic           RESET,
    flood_engine_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, SEED, SWEEP, DONE} state_t;

    state_t state, state_n;

    logic [2:0] colour_mem [1024];
    logic       owned_mem  [1024];

    logic       ack, ack_n;
    logic       changing, changing_n;
    logic       initialized, initialized_n;
    logic [2:0] target, target_n;
    logic [4:0] row, row_n, col, col_n;
    logic [9:0] clear_addr, clear_addr_n;
    logic       changed, changed_n;
    logic       sel_block, sel_block_n;

    logic       colour_we;
    logic [9:0] colour_waddr;
    logic [2:0] colour_wdata;
    logic       owned_we;
    logic [9:0] owned_waddr;
    logic       owned_wdata;

    logic [4:0] last, row_up, row_dn, col_lf, col_rt;
    logic [9:0] cur_addr;
    logic [2:0] cur_colour;
    logic       cur_owned, nb_owned, absorb, pass_end, sel_legal;

`ifdef FLOOD_WIN_DETECT_EN
    logic [10:0] owned_count, owned_count_n, area;
    logic        game_won, game_won_n;

    assign area = {6'd0, bus.final_SIZE} * {6'd0, bus.final_SIZE};
`endif

    assign last       = bus.final_SIZE - 5'd1;
    assign row_up     = row - 5'd1;
    assign row_dn     = row + 5'd1;
    assign col_lf     = col - 5'd1;
    assign col_rt     = col + 5'd1;
    assign cur_addr   = {row, col};
    assign cur_owned  = owned_mem[cur_addr];
    assign cur_colour = colour_mem[cur_addr];

    // Neighbours beyond the active SIZE x SIZE region never count as owned.
    assign nb_owned = ((row != 5'd0) && owned_mem[{row_up, col}]) ||
                      ((row != last) && owned_mem[{row_dn, col}]) ||
                      ((col != 5'd0) && owned_mem[{row, col_lf}]) ||
                      ((col != last) && owned_mem[{row, col_rt}]);

    assign absorb    = (state == SWEEP) && !cur_owned && (cur_colour == target) && nb_owned;
    assign pass_end  = (row == last) && (col == last);
    // A colour outside the palette in play is not a legal move.
    assign sel_legal = ({1'b0, bus.COLOR_SELECTED} < bus.final_COLOR_NUM);

    always_comb begin
        state_n       = state;
        ack_n         = ack;
        changing_n    = changing;
        initialized_n = initialized;
        target_n      = target;
        row_n         = row;
        col_n         = col;
        clear_addr_n  = clear_addr;
        changed_n     = changed;
        sel_block_n   = sel_block;
        colour_we     = 1'b0;
        colour_waddr  = cur_addr;
        colour_wdata  = target;
        owned_we      = 1'b0;
        owned_waddr   = cur_addr;
        owned_wdata   = 1'b1;
`ifdef FLOOD_WIN_DETECT_EN
        owned_count_n = owned_count;
        game_won_n    = game_won;
`endif
        if (!bus.BEGIN_GAME) ack_n = 1'b0;
        // A held move request must be seen low once before another move is taken.
        if (!bus.COLOR_SEL_SIG) sel_block_n = 1'b0;

        case (state)
            IDLE: begin
                if (bus.LOAD_WE) begin
                    colour_we    = 1'b1;
                    colour_waddr = bus.LOAD_ADDR;
                    colour_wdata = bus.LOAD_COLOR;
                end
                if (bus.BEGIN_GAME) begin
                    ack_n         = 1'b1;
                    initialized_n = 1'b0;
                    clear_addr_n  = 10'd0;
                    sel_block_n   = bus.COLOR_SEL_SIG;
                    state_n       = CLEAR;
`ifdef FLOOD_WIN_DETECT_EN
                    game_won_n    = 1'b0;
`endif
                end else if (initialized && bus.COLOR_SEL_SIG && !sel_block && sel_legal) begin
                    target_n    = bus.COLOR_SELECTED;
                    changing_n  = 1'b1;
                    row_n       = 5'd0;
                    col_n       = 5'd0;
                    changed_n   = 1'b0;
                    sel_block_n = 1'b1;
                    state_n     = SWEEP;
                end
            end
            CLEAR: begin
                owned_we     = 1'b1;
                owned_waddr  = clear_addr;
                owned_wdata  = 1'b0;
                clear_addr_n = clear_addr + 10'd1;
`ifdef FLOOD_WIN_DETECT_EN
                owned_count_n = 11'd0;
`endif
                if (clear_addr == 10'd1023) state_n = SEED;
            end
            SEED: begin
                owned_we    = 1'b1;
                owned_waddr = 10'd0;
                target_n    = colour_mem[0];
                row_n       = 5'd0;
                col_n       = 5'd0;
                changed_n   = 1'b0;
                state_n     = SWEEP;
`ifdef FLOOD_WIN_DETECT_EN
                owned_count_n = owned_count + 11'd1;
`endif
            end
            SWEEP: begin
                colour_we = cur_owned;
                owned_we  = absorb;
`ifdef FLOOD_WIN_DETECT_EN
                if (absorb) owned_count_n = owned_count + 11'd1;
`endif
                if (pass_end) begin
                    row_n     = 5'd0;
                    col_n     = 5'd0;
                    changed_n = 1'b0;
                    if (!(changed || absorb)) begin
                        state_n       = DONE;
                        initialized_n = 1'b1;
                        changing_n    = 1'b0;
`ifdef FLOOD_WIN_DETECT_EN
                        game_won_n    = (owned_count == area);
`endif
                    end
                end else begin
                    changed_n = changed || absorb;
                    if (col == last) begin
                        col_n = 5'd0;
                        row_n = row + 5'd1;
                    end else begin
                        col_n = col + 5'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            ack         <= 1'b0;
            changing    <= 1'b0;
            initialized <= 1'b0;
            target      <= 3'd0;
            row         <= 5'd0;
            col         <= 5'd0;
            clear_addr  <= 10'd0;
            changed     <= 1'b0;
            sel_block   <= 1'b0;
`ifdef FLOOD_WIN_DETECT_EN
            owned_count <= 11'd0;
            game_won    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            ack         <= ack_n;
            changing    <= changing_n;
            initialized <= initialized_n;
            target      <= target_n;
            row         <= row_n;
            col         <= col_n;
            clear_addr  <= clear_addr_n;
            changed     <= changed_n;
            sel_block   <= sel_block_n;
`ifdef FLOOD_WIN_DETECT_EN
            owned_count <= owned_count_n;
            game_won    <= game_won_n;
`endif
        end
    end

    // Board storage keeps its contents across reset; only a new game rebuilds ownership.
    always_ff @(posedge MASTER_CLOCK) begin
        if (colour_we) colour_mem[colour_waddr] <= colour_wdata;
        if (owned_we)  owned_mem[owned_waddr]   <= owned_wdata;
    end

    assign bus.ACK_BEGIN_GAME           = ack;
    assign bus.CURRENTLY_CHANGING_COLOR = changing;
    assign bus.INITIALIZED              = initialized;
    assign bus.RD_COLOR                 = colour_mem[bus.RD_ADDR];
    assign bus.RD_OWNED                 = owned_mem[bus.RD_ADDR];
`ifdef FLOOD_WIN_DETECT_EN
    assign bus.GAME_WON                 = game_won;
`else
    assign bus.GAME_WON                 = 1'b0;
`endif

endmodule

// File: tb/tb_flood_engine.sv
// Directed bench for flood_engine: 2x2 games, same-colour move, reset mid-sweep, 26x26 serpentine.
module tb_flood_engine;

    logic MASTER_CLOCK = 1'b0;
    logic RESET;

    flood_engine_if bus ();

    flood_engine dut (
        .MASTER_CLOCK(MASTER_CLOCK),
        .RESET       (RESET),
        .bus         (bus)
    );

    always #5 MASTER_CLOCK = ~MASTER_CLOCK;

`ifdef FLOOD_WIN_DETECT_EN
    localparam int WIN_EN = 1;
`else
    localparam int WIN_EN = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         phase;
        logic [4:0] row;
        logic [4:0] col;
        logic [2:0] colour;
        logic       owned;
    } rd_vec_t;

    rd_vec_t vecs[$];

    function automatic rd_vec_t mk(int phase, int r, int c, int colour, int owned);
        rd_vec_t v;
        v.phase  = phase;
        v.row    = 5'(r);
        v.col    = 5'(c);
        v.colour = 3'(colour);
        v.owned  = 1'(owned);
        return v;
    endfunction

    // 26x26 serpentine: row 0 -> (1,25) -> row 2 right-to-left -> (3,0), all colour 1.
    function automatic int path_colour(int r, int c);
        if (r == 0) return (c == 0) ? 0 : 1;
        if (r == 1) return (c == 25) ? 1 : 2;
        if (r == 2) return 1;
        if (r == 3) return (c == 0) ? 1 : 2;
        return 2;
    endfunction

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(int r, int c, int colour);
        bus.LOAD_WE    = 1'b1;
        bus.LOAD_ADDR  = {5'(r), 5'(c)};
        bus.LOAD_COLOR = 3'(colour);
        @(negedge MASTER_CLOCK);
        bus.LOAD_WE    = 1'b0;
    endtask

    task automatic check_output(int phase);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == phase) begin
                bus.RD_ADDR = {vecs[i].row, vecs[i].col};
                #1;
                check($sformatf("p%0d_colour_r%0d_c%0d", phase, vecs[i].row, vecs[i].col),
                      int'(bus.RD_COLOR), int'(vecs[i].colour));
                check($sformatf("p%0d_owned_r%0d_c%0d", phase, vecs[i].row, vecs[i].col),
                      int'(bus.RD_OWNED), int'(vecs[i].owned));
            end
        end
        @(negedge MASTER_CLOCK);
    endtask

    task automatic start_game(logic with_sel);
        bus.BEGIN_GAME    = 1'b1;
        bus.COLOR_SEL_SIG = with_sel;
        @(negedge MASTER_CLOCK);
        check("begin_ack", int'(bus.ACK_BEGIN_GAME), 1);
        check("begin_init_low", int'(bus.INITIALIZED), 0);
        check("begin_beats_sel", int'(bus.CURRENTLY_CHANGING_COLOR), 0);
        bus.BEGIN_GAME    = 1'b0;
        bus.COLOR_SEL_SIG = 1'b0;
        @(negedge MASTER_CLOCK);
        check("ack_clear", int'(bus.ACK_BEGIN_GAME), 0);
    endtask

    task automatic wait_init(int bound, string name);
        int n = 0;
        while (!bus.INITIALIZED && n < bound) begin
            @(negedge MASTER_CLOCK);
            n++;
        end
        check(name, int'(bus.INITIALIZED), 1);
    endtask

    task automatic select_colour(int colour, logic hold, int bound, output int cycles);
        int n = 0;
        bus.COLOR_SELECTED = 3'(colour);
        bus.COLOR_SEL_SIG  = 1'b1;
        while (!bus.CURRENTLY_CHANGING_COLOR && n < 4) begin
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("sel_accept", int'(bus.CURRENTLY_CHANGING_COLOR), 1);
        if (!hold) bus.COLOR_SEL_SIG = 1'b0;
        cycles = 0;
        while (bus.CURRENTLY_CHANGING_COLOR && cycles < bound) begin
            cycles++;
            @(negedge MASTER_CLOCK);
        end
        check("sel_done", int'(bus.CURRENTLY_CHANGING_COLOR), 0);
        check("sel_init_kept", int'(bus.INITIALIZED), 1);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        int  n;
        logic seen;

        RESET              = 1'b1;
        bus.final_SIZE     = 5'd2;
        bus.final_COLOR_NUM = 4'd3;
        bus.BEGIN_GAME     = 1'b0;
        bus.COLOR_SEL_SIG  = 1'b0;
        bus.COLOR_SELECTED = 3'd0;
        bus.LOAD_WE        = 1'b0;
        bus.LOAD_ADDR      = 10'd0;
        bus.LOAD_COLOR     = 3'd0;
        bus.RD_ADDR        = 10'd0;

        // 2x2 board {0,0,1,2} after the opening flood, after colour 1, after colour 2.
        vecs.push_back(mk(1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2, 0));
        vecs.push_back(mk(2, 0, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 1, 1));
        vecs.push_back(mk(2, 1, 0, 1, 1));
        vecs.push_back(mk(2, 1, 1, 2, 0));
        vecs.push_back(mk(3, 0, 0, 2, 1));
        vecs.push_back(mk(3, 0, 1, 2, 1));
        vecs.push_back(mk(3, 1, 0, 2, 1));
        vecs.push_back(mk(3, 1, 1, 2, 1));
        // Serpentine after colour 1, including cells outside the 26x26 region.
        vecs.push_back(mk(4, 0, 0, 1, 1));
        vecs.push_back(mk(4, 0, 25, 1, 1));
        vecs.push_back(mk(4, 1, 25, 1, 1));
        vecs.push_back(mk(4, 2, 13, 1, 1));
        vecs.push_back(mk(4, 2, 0, 1, 1));
        vecs.push_back(mk(4, 3, 0, 1, 1));
        vecs.push_back(mk(4, 1, 0, 2, 0));
        vecs.push_back(mk(4, 3, 1, 2, 0));
        vecs.push_back(mk(4, 4, 0, 2, 0));
        vecs.push_back(mk(4, 5, 5, 2, 0));
        vecs.push_back(mk(4, 25, 25, 2, 0));
        vecs.push_back(mk(4, 0, 26, 1, 0));
        vecs.push_back(mk(4, 26, 0, 1, 0));
        // Serpentine after colour 2: whole active region owned, outside untouched.
        vecs.push_back(mk(5, 0, 0, 2, 1));
        vecs.push_back(mk(5, 1, 0, 2, 1));
        vecs.push_back(mk(5, 5, 5, 2, 1));
        vecs.push_back(mk(5, 25, 25, 2, 1));
        vecs.push_back(mk(5, 0, 26, 1, 0));
        vecs.push_back(mk(5, 26, 0, 1, 0));
        // Fresh 2x2 game after the abandoned move left colour[0]=1.
        vecs.push_back(mk(6, 0, 0, 1, 1));
        vecs.push_back(mk(6, 0, 1, 2, 0));
        vecs.push_back(mk(6, 1, 1, 2, 0));

        repeat (3) @(negedge MASTER_CLOCK);
        check("rst_ack", int'(bus.ACK_BEGIN_GAME), 0);
        check("rst_changing", int'(bus.CURRENTLY_CHANGING_COLOR), 0);
        check("rst_init", int'(bus.INITIALIZED), 0);
        check("rst_won", int'(bus.GAME_WON), 0);
        RESET = 1'b0;
        @(negedge MASTER_CLOCK);

        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(1, 0, 1);
        apply_stimulus(1, 1, 2);
        start_game(1'b0);
        wait_init(3000, "init_size2");
        check_output(1);
        check("won_p1", int'(bus.GAME_WON), 0);

        select_colour(1, 1'b0, 100, cyc);
        check("move1_cycles", cyc, 8);
        check_output(2);
        check("won_p2", int'(bus.GAME_WON), 0);

        // Same colour as the flood: one pass only, and a held request is not retaken.
        select_colour(1, 1'b1, 100, cyc);
        check("same_colour_cycles", cyc, 4);
        seen = 1'b0;
        repeat (10) begin
            @(negedge MASTER_CLOCK);
            if (bus.CURRENTLY_CHANGING_COLOR) seen = 1'b1;
        end
        check("held_sel_ignored", int'(seen), 0);
        bus.COLOR_SEL_SIG = 1'b0;
        @(negedge MASTER_CLOCK);
        check_output(2);

        select_colour(2, 1'b0, 100, cyc);
        check("move2_cycles", cyc, 8);
        check_output(3);
        check("won_p3", int'(bus.GAME_WON), WIN_EN);

        // Reset one cycle into a sweep.
        bus.COLOR_SELECTED = 3'd1;
        bus.COLOR_SEL_SIG  = 1'b1;
        n = 0;
        while (!bus.CURRENTLY_CHANGING_COLOR && n < 4) begin
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("rst_sel_accept", int'(bus.CURRENTLY_CHANGING_COLOR), 1);
        bus.COLOR_SEL_SIG = 1'b0;
        @(negedge MASTER_CLOCK);
        RESET = 1'b1;
        #1;
        check("midsweep_ack", int'(bus.ACK_BEGIN_GAME), 0);
        check("midsweep_changing", int'(bus.CURRENTLY_CHANGING_COLOR), 0);
        check("midsweep_init", int'(bus.INITIALIZED), 0);
        check("midsweep_won", int'(bus.GAME_WON), 0);
        @(negedge MASTER_CLOCK);
        @(negedge MASTER_CLOCK);
        RESET = 1'b0;
        @(negedge MASTER_CLOCK);

        bus.COLOR_SELECTED = 3'd2;
        bus.COLOR_SEL_SIG  = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge MASTER_CLOCK);
            if (bus.CURRENTLY_CHANGING_COLOR) seen = 1'b1;
        end
        bus.COLOR_SEL_SIG = 1'b0;
        check("sel_ignored_uninit", int'(seen), 0);
        @(negedge MASTER_CLOCK);

        start_game(1'b0);
        wait_init(3000, "init_after_reset");
        check_output(6);
        check("won_p6", int'(bus.GAME_WON), 0);

        // 26x26 serpentine; the game starts with BEGIN_GAME and COLOR_SEL_SIG together.
        bus.final_SIZE = 5'd26;
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                apply_stimulus(r, c, path_colour(r, c));
        apply_stimulus(0, 26, 1);
        apply_stimulus(26, 0, 1);
        start_game(1'b1);
        apply_stimulus(5, 5, 1);
        wait_init(5000, "init_size26");

        select_colour(1, 1'b0, 30000, cyc);
        check_output(4);
        check("won_p4", int'(bus.GAME_WON), 0);

        select_colour(2, 1'b0, 5000, cyc);
        check_output(5);
        check("won_p5", int'(bus.GAME_WON), WIN_EN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
